// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arb_pkg                                                     |
// | Shared types and width helper for the data-memory arbiter.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } arb_owner_t;

  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;

  // Request bundle sized for the default data memory geometry.
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [3:0]             be;
  } mem_req_t;

  // Bits needed to hold values 0..max_val (latency and starvation counters).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_select.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arb_select                                                  |
// | Combinational winner selection between core and debug requests.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_arb_select
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int STV_W      = cnt_width(STARVE_MAX)
) (
  input  logic             en,
  input  logic             c_req,
  input  logic             d_req,
  input  logic             lock,
  input  logic [STV_W-1:0] starve_cnt,
  output logic             gnt_c,
  output logic             gnt_d
);

  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

  logic dbg_turn;

  assign dbg_turn = (starve_cnt == STV_LIMIT);

  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (en) begin
      // A held lock removes the core from contention entirely.
      if (lock) begin
        gnt_d = d_req;
      end else if (d_req && (!c_req || dbg_turn)) begin
        gnt_d = 1'b1;
      end else begin
        gnt_c = c_req;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter                                                     |
// | Shares the single-ported data memory between core and debug      |
// | port; optional debug lock via DMEM_ARB_LOCK_EN.                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [3:0]        c_be,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              d_lock,
`endif
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = cnt_width(MEM_LAT);
  localparam int STV_W = cnt_width(STARVE_MAX);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_WAIT = WAIT;

  logic [0:0]       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic     en_arb;
  logic     gnt_c;
  logic     gnt_d;
  logic     gnt_any;
  logic     lock_active;
  logic     core_rd_pend;
  mem_req_t win;

  // Reset is folded in so every output drops the instant rst_n falls.
  assign en_arb = rst_n && (state_q == ST_IDLE);

  dmem_arb_select #(
    .STARVE_MAX (STARVE_MAX),
    .STV_W      (STV_W)
  ) u_select (
    .en         (en_arb),
    .c_req      (c_req),
    .d_req      (d_req),
    .lock       (lock_active),
    .starve_cnt (starve_q),
    .gnt_c      (gnt_c),
    .gnt_d      (gnt_d)
  );

`ifdef DMEM_ARB_LOCK_EN
  logic last_dbg_q, last_dbg_d;

  assign last_dbg_d  = gnt_any ? gnt_d : last_dbg_q;
  assign lock_active = d_lock && last_dbg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg_q <= 1'b0;
    end else begin
      last_dbg_q <= last_dbg_d;
    end
  end
`else
  assign lock_active = 1'b0;
`endif

  assign c_gnt   = gnt_c;
  assign d_gnt   = gnt_d;
  assign gnt_any = gnt_c || gnt_d;

  always_comb begin
    win = '0;
    if (gnt_c) begin
      win.we    = c_we;
      win.addr  = DMEM_ADDR_W'(c_addr);
      win.wdata = DMEM_DATA_W'(c_wdata);
      win.be    = c_be;
    end else if (gnt_d) begin
      win.we    = d_we;
      win.addr  = DMEM_ADDR_W'(d_addr);
      win.wdata = DMEM_DATA_W'(d_wdata);
      win.be    = d_be;
    end
  end

  assign mem_wr    = gnt_any && win.we;
  assign mem_rd    = gnt_any && !win.we;
  assign mem_addr  = ADDR_W'(win.addr);
  assign mem_wdata = DATA_W'(win.wdata);
  assign mem_be    = win.be;

  always_comb begin
    starve_d = starve_q;
    if (!lock_active) begin
      if (!d_req || gnt_d) begin
        starve_d = '0;
      end else if (gnt_c) begin
        starve_d = starve_q + STV_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lat_d    = lat_q;
    c_rvalid = 1'b0;
    d_rvalid = 1'b0;
    c_rdata  = '0;
    d_rdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (mem_rd) begin
          state_d = ST_WAIT;
          lat_d   = LAT_LOAD;
          owner_d = gnt_d ? OWN_DBG : OWN_CORE;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_DBG) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            c_rvalid = 1'b1;
            c_rdata  = mem_rdata;
          end
        end else begin
          lat_d = lat_q - LAT_LAST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The grant cycle of a core read already counts as an outstanding read.
  assign core_rd_pend = (gnt_c && !win.we) ||
                        ((state_q == ST_WAIT) && (owner_q == OWN_CORE) && !c_rvalid);
  assign c_stall      = rst_n && ((c_req && !gnt_c) || core_rd_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_CORE;
      lat_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_arbiter                                                  |
// | Scoreboard bench for dmem_arbiter with a latency-accurate memory.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              c_req, c_we, c_gnt, c_rvalid, c_stall;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic [3:0]        c_be;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [3:0]        d_be;
`ifdef DMEM_ARB_LOCK_EN
  logic              d_lock;
`endif
  logic              mem_wr, mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [3:0]        mem_be;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_be      (c_be),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .c_stall   (c_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
`ifdef DMEM_ARB_LOCK_EN
    .d_lock    (d_lock),
`endif
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_rv  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [8:0] a);
    if (a == 9'h020) return 32'h12345678;
    return {7'h55, a, ~a[7:0], a[7:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory model driven only by the DUT's memory bus.
  logic [31:0] mem_arr [512];
  bit          mem_wrt [512];
  logic [31:0] rd_pipe [MEM_LAT];

  always @(posedge clk) begin
    if (mem_wr) begin
      mem_arr[mem_addr] <= merge(mem_wrt[mem_addr] ? mem_arr[mem_addr] : pat(mem_addr),
                                 mem_wdata, mem_be);
      mem_wrt[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= mem_rd ? (mem_wrt[mem_addr] ? mem_arr[mem_addr] : pat(mem_addr)) : 32'h0;
    for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // Scoreboard: shadow memory built from the bench's own granted stimulus.
  typedef struct {
    bit          dbg;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [$];
  bit          gnt_log [$];
  logic [31:0] sh_arr [512];
  bit          sh_wrt [512];
  exp_t        e;

  function automatic logic [31:0] sh_rd(input logic [8:0] a);
    return sh_wrt[a] ? sh_arr[a] : pat(a);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("gnt_excl", c_gnt & d_gnt, 0);
      if (c_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("rv_unexpected", {c_rvalid, d_rvalid}, 0);
        end else begin
          e = exp_q.pop_front();
          n_rv++;
          chk("rv_owner", {c_rvalid, d_rvalid}, e.dbg ? 2'b01 : 2'b10);
          chk("rv_rdata", e.dbg ? d_rdata : c_rdata, e.data);
          chk("rv_other", e.dbg ? c_rdata : d_rdata, 0);
        end
      end
      if (c_gnt) begin
        gnt_log.push_back(1'b0);
        if (c_we) begin
          sh_arr[c_addr] = merge(sh_rd(c_addr), c_wdata, c_be);
          sh_wrt[c_addr] = 1'b1;
        end else begin
          exp_q.push_back('{1'b0, sh_rd(c_addr)});
        end
      end else if (d_gnt) begin
        gnt_log.push_back(1'b1);
        if (d_we) begin
          sh_arr[d_addr] = merge(sh_rd(d_addr), d_wdata, d_be);
          sh_wrt[d_addr] = 1'b1;
        end else begin
          exp_q.push_back('{1'b1, sh_rd(d_addr)});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         base;
    bit         done;
    logic [7:0] dreq_pat;

    rst_n = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
`ifdef DMEM_ARB_LOCK_EN
    d_lock = 1'b0;
`endif

    // Reset with requests present: nothing may leak out.
    step();
    c_req = 1'b1; c_we = 1'b1; d_req = 1'b1; c_addr = 9'h1FF; c_be = 4'hF; d_be = 4'hF;
    #1;
    chk("rst_ctl", {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_wr, mem_rd, c_stall}, 0);
    chk("rst_bus", {mem_addr, mem_be, mem_wdata}, 0);
    chk("rst_rdata", {c_rdata, d_rdata}, 0);
    c_req = 1'b0; d_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Core write, then a back-to-back partial write.
    c_req = 1'b1; c_we = 1'b1; c_addr = 9'h010; c_wdata = 32'hDEADBEEF; c_be = 4'hF;
    @(negedge clk);
    chk("wr_gnt", c_gnt, 1);
    chk("wr_mem_wr", {mem_wr, mem_rd}, 2'b10);
    chk("wr_addr", mem_addr, 9'h010);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_stall", c_stall, 0);
    step();
    c_wdata = 32'h11223344; c_be = 4'b0101;
    @(negedge clk);
    chk("wr2_gnt", c_gnt, 1);
    chk("wr2_be", mem_be, 4'b0101);
    step();
    c_req = 1'b0;

    // Core read with latency 2.
    step();
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'h020;
    @(negedge clk);
    chk("rd_t0_gnt", {c_gnt, mem_rd, c_stall}, 3'b111);
    chk("rd_t0_addr", mem_addr, 9'h020);
    step();
    c_req = 1'b0;
    @(negedge clk);
    chk("rd_t1", {c_rvalid, mem_rd, c_stall}, 3'b001);
    step();
    @(negedge clk);
    chk("rd_t2_rvalid", c_rvalid, 1);
    chk("rd_t2_rdata", c_rdata, 32'h12345678);
    chk("rd_t2_stall", c_stall, 0);
    step();

    // Debug request raised during WAIT must wait for IDLE.
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010;
    @(negedge clk);
    chk("wt_c_gnt", c_gnt, 1);
    step();
    c_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h070; d_wdata = 32'hCAFEF00D; d_be = 4'hF;
    @(negedge clk);
    chk("wt_d_gnt1", {d_gnt, mem_wr}, 0);
    step();
    @(negedge clk);
    chk("wt_d_gnt2", d_gnt, 0);
    chk("wt_rdata", {c_rvalid, c_rdata}, {1'b1, 32'hDE22BE44});
    step();
    @(negedge clk);
    chk("wt_d_gnt3", {d_gnt, mem_wr}, 2'b11);
    chk("wt_d_addr", mem_addr, 9'h070);
    step();
    d_req = 1'b0;

    // Core wins by default, debug follows.
    c_req = 1'b1; c_we = 1'b1; c_addr = 9'h100; c_wdata = 32'h0BADF00D;
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h101; d_wdata = 32'h600DCAFE;
    @(negedge clk);
    chk("prio_both", {c_gnt, d_gnt}, 2'b10);
    step();
    c_req = 1'b0;
    @(negedge clk);
    chk("prio_d_next", {c_gnt, d_gnt}, 2'b01);
    step();
    d_req = 1'b0;

    // Starvation counter clears when debug drops its request.
    dreq_pat = 8'b1111_1011;
    for (int i = 0; i < 8; i++) begin
      c_req = 1'b1; c_we = 1'b1; c_addr = 9'h110 + 9'(i); c_wdata = 32'(i);
      d_req = dreq_pat[i]; d_we = 1'b1; d_addr = 9'h120; d_wdata = 32'hD0D0D0D0;
      @(negedge clk);
      chk($sformatf("clr_gnt%0d", i), {c_gnt, d_gnt}, (i == 7) ? 2'b01 : 2'b10);
      step();
    end
    c_req = 1'b0; d_req = 1'b0;

    // Both ports reading continuously: C,C,C,C,D repeating.
    base = gnt_log.size();
    done = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'h030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h040;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      #1;
      if (gnt_log.size() - base >= 10) done = 1'b1;
      else step();
    end
    step();
    c_req = 1'b0; d_req = 1'b0;
    chk("starve_done", done, 1);
    for (int i = 0; i < 10; i++) begin
      if (base + i < gnt_log.size())
        chk($sformatf("starve_ord%0d", i), gnt_log[base+i], (i % 5 == 4) ? 1 : 0);
    end
    repeat (MEM_LAT + 1) step();

    // Reset during WAIT of a debug read.
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h040;
    @(negedge clk);
    chk("mr_d_gnt", d_gnt, 1);
    step();
    d_req = 1'b0;
    #2;
    rst_n = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 9'h080; c_wdata = 32'h80808080; c_be = 4'hF;
    #1;
    chk("mr_ctl", {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_wr, mem_rd, c_stall}, 0);
    chk("mr_bus", {mem_addr, mem_be, mem_wdata}, 0);
    chk("mr_rdata", {c_rdata, d_rdata}, 0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", {c_gnt, mem_wr}, 2'b11);
    chk("post_rst_addr", mem_addr, 9'h080);
    step();
    c_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("no_d_rvalid%0d", i), d_rvalid, 0);
      step();
    end

`ifdef DMEM_ARB_LOCK_EN
    // Debug lock: core excluded until d_lock drops.
    d_lock = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 9'h130; d_wdata = 32'h13131313;
    @(negedge clk);
    chk("lk_first", d_gnt, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      c_req = 1'b1; c_we = 1'b1; c_addr = 9'h140; c_wdata = 32'h14141414;
      d_addr = 9'h131 + 9'(i);
      @(negedge clk);
      chk($sformatf("lk_gnt%0d", i), {c_gnt, d_gnt, c_stall}, 3'b011);
    end
    step();
    d_lock = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("lk_release", {c_gnt, c_stall}, 2'b10);
    step();
    c_req = 1'b0;
`endif

    repeat (MEM_LAT + 2) step();
    chk("sb_drain", exp_q.size(), 0);
    chk("rv_count", n_rv, 12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer that shares the single-ported data memory between the core's MEM stage and a debug/loader port. It serialises requests, drives the memory control/address/data lines, tracks the fixed read latency, routes read data back to the owner, and generates the core pipeline stall. It sits between the datapath's MEM stage and the data memory instance.

## Interface
- ADDR_W, 9, word address width (matches the data memory's `addr`)
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles, legal range 1..4
- STARVE_MAX, 4, consecutive core grants allowed while debug waits
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_req / c_we  in  1  core request / write (1) or read (0)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core store data
- c_be  in  4  core byte enables
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core read data valid this cycle
- c_rdata  out  DATA_W  core read data
- c_stall  out  1  freeze core pipeline
- d_req, d_we, d_addr, d_wdata, d_be  in  as the core fields  debug request
- d_gnt, d_rvalid, d_rdata  out  as the core fields  debug handshake and data
- mem_wr / mem_rd  out  1  memory write / read strobe, one cycle per access
- mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W;  mem_be  out  4
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after `mem_rd`

## Operation
- FSM states: IDLE, WAIT. Owner register: CORE or DBG.
- IDLE: if any request is pending, select a winner, drive `mem_*` combinationally from the winner's fields, and assert its `gnt` in the same cycle.
  - Write: remain in IDLE; a new grant is possible next cycle.
  - Read: load the latency counter with MEM_LAT, latch the owner, go to WAIT.
- WAIT: no grants; `mem_wr = mem_rd = 0`; decrement the counter each cycle. When it reaches 1, assert the owner's `rvalid`, route `mem_rdata` to the owner's `rdata`, and return to IDLE.
- Arbitration: core wins by default. The starvation counter increments on each core grant while `d_req = 1`.
  - If `d_req = 1` and the counter equals STARVE_MAX, debug wins and the counter clears.
  - The counter clears whenever `d_req = 0`.
- Requesters hold `req`, `we`, `addr`, `wdata` and `be` stable until `gnt`.
- `c_stall` is asserted in either of these cases:
  - `c_req & ~c_gnt`;
  - the core owns an outstanding read and `c_rvalid = 0`, which includes the grant cycle of a core read.
- `rdata` of the non-owner is 0. Sign and size extension of loads remains in the datapath.

## Timing
- Reset low forces immediately: state IDLE, owner CORE, counters 0. All `gnt`, `rvalid`, `mem_wr`, `mem_rd` and `c_stall` are 0, and `mem_addr`, `mem_wdata`, `mem_be` and both `rdata` are 0.
- Reset mid-read discards the outstanding read; no `rvalid` is produced after release.
- Write: grant and `mem_wr` in cycle T; throughput 1 per cycle.
- Read: grant and `mem_rd` in cycle T; `rvalid` in cycle T+MEM_LAT; next grant no earlier than T+MEM_LAT+1.
- A request that rises during WAIT waits. It is arbitrated in the first IDLE cycle.

## Configuration
- DMEM_ARB_LOCK_EN: adds input `d_lock` (1 bit).
  - While `d_lock = 1` and the last grant went to debug, the core is excluded from arbitration, `c_stall` follows `c_req`, and the starvation counter is frozen.
  - The lock releases on the first cycle with `d_lock = 0`.
- Without the macro: no `d_lock` port; arbitration is exactly as in Operation.

## Structure
- Package `dmem_arb_pkg`:
  - enum `arb_state_t` {IDLE, WAIT};
  - enum `arb_owner_t` {OWN_CORE, OWN_DBG};
  - struct `mem_req_t` {we, addr, wdata, be};
  - function computing the counter widths from MEM_LAT and STARVE_MAX.
- Sub-module `dmem_arb_select`: combinational winner selection from the two requests, starvation count and lock. All state stays in `dmem_arbiter`.

## Test plan
- Core write only: `c_req=1`, `c_we=1`, `c_addr=0x010`, `c_wdata=0xDEADBEEF`, `c_be=0xF`. Required: `c_gnt`, `mem_wr`, `mem_addr=0x010` in the same cycle; `c_stall=0`.
- Core read, MEM_LAT=2, memory returns 0x12345678. Required: `mem_rd` at T, `c_rvalid` with `c_rdata=0x12345678` at T+2, `c_stall=1` for T..T+1.
- Core and debug reads every cycle, MEM_LAT=1, STARVE_MAX=4. Required grant order: C, C, C, C, D, repeating; every `rvalid` goes to the correct owner.
- Reset pulled low during WAIT of a debug read. Required: all outputs 0 immediately; no `d_rvalid` after release; first post-reset request granted in IDLE.
- With DMEM_ARB_LOCK_EN, `d_lock=1` and four debug writes. Required: four consecutive `d_gnt`, `c_stall=1` throughout; core granted the cycle after `d_lock=0`.
